// File: rtl/axil_read_arbiter_pkg.sv
// Shared constants for the two-port AXI4-Lite read arbiter: bus width,
// RRESP codes, arbiter state and owner encodings.
package axil_read_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int DEFAULT_MAX_DATA_STREAK = 4;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // One-hot owner, bit order {S1,S0}.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_S0   = 2'b01;
  localparam logic [1:0] OWNER_S1   = 2'b10;

endpackage

// File: rtl/axil_read_arbiter_if.sv
// AXI4-Lite read channel bundle (AR + R) used for both requester and
// downstream sides of the arbiter.
interface axil_read_arbiter_if;
  import axil_read_arbiter_pkg::*;

  // A beat transfers on a rising clock edge where valid && ready; the sender
  // holds valid and its payload stable until that edge, ready may toggle freely.
  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid);

endinterface

// File: rtl/axil_arb_priority_sel.sv
// Winner select for the read arbiter: strict S1 priority, with an S1 streak
// counter that hands one grant to S0 when ARB_STARVATION_GUARD_EN is defined.
module axil_arb_priority_sel
`ifdef ARB_STARVATION_GUARD_EN
#(
  parameter int MAX_DATA_STREAK = 4
)
`endif
(
`ifdef ARB_STARVATION_GUARD_EN
  input  logic i_Clock,
  input  logic i_Reset_N,
`endif
  input  logic arb_en,
  input  logic s0_req,
  input  logic s1_req,
  output logic grant_s0,
  output logic grant_s1
);

`ifdef ARB_STARVATION_GUARD_EN
  logic [2:0] streak_q;
  logic       force_s0;

  assign force_s0 = (streak_q == 3'(MAX_DATA_STREAK));

  always_comb begin
    grant_s0 = 1'b0;
    grant_s1 = 1'b0;
    if (arb_en) begin
      if (s1_req && !(force_s0 && s0_req)) grant_s1 = 1'b1;
      else if (s0_req)                     grant_s0 = 1'b1;
    end
  end

  // Counts S1 wins only while S0 is kept waiting; saturates at 7.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      streak_q <= 3'd0;
    end else if (grant_s0) begin
      streak_q <= 3'd0;
    end else if (grant_s1) begin
      if (!s0_req)                streak_q <= 3'd0;
      else if (streak_q != 3'd7)  streak_q <= streak_q + 3'd1;
    end
  end
`else
  always_comb begin
    grant_s0 = 1'b0;
    grant_s1 = 1'b0;
    if (arb_en) begin
      if (s1_req)      grant_s1 = 1'b1;
      else if (s0_req) grant_s0 = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/axil_read_arbiter.sv
// Shares one AXI4-Lite read master between instruction fetch (S0) and data
// load (S1), one transaction in flight. Optional macro: ARB_STARVATION_GUARD_EN.
module axil_read_arbiter
  import axil_read_arbiter_pkg::*;
`ifdef ARB_STARVATION_GUARD_EN
#(
  parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
)
`endif
(
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  axil_read_arbiter_if.slave        s0_axil,
  axil_read_arbiter_if.slave        s1_axil,
  axil_read_arbiter_if.master       m_axil,
  output logic                      o_Busy,
  output logic [1:0]                o_Grant,
  output arb_state_e                dbg_state
);

  arb_state_e      state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [XLEN-1:0] araddr_q, araddr_d;
  logic            arb_en, grant_s0, grant_s1, r_ready;

  // No grant while reset is asserted so every ready stays low in that cycle.
  assign arb_en = (state_q == ARB_IDLE) && i_Reset_N;

  axil_arb_priority_sel
`ifdef ARB_STARVATION_GUARD_EN
    #(.MAX_DATA_STREAK(MAX_DATA_STREAK))
`endif
  u_sel (
`ifdef ARB_STARVATION_GUARD_EN
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
`endif
    .arb_en    (arb_en),
    .s0_req    (s0_axil.arvalid),
    .s1_req    (s1_axil.arvalid),
    .grant_s0  (grant_s0),
    .grant_s1  (grant_s1)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_N) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_NONE;
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      araddr_q <= araddr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    araddr_d         = araddr_q;
    s0_axil.arready  = grant_s0;
    s1_axil.arready  = grant_s1;
    s0_axil.rvalid   = 1'b0;
    s0_axil.rdata    = '0;
    s0_axil.rresp    = '0;
    s1_axil.rvalid   = 1'b0;
    s1_axil.rdata    = '0;
    s1_axil.rresp    = '0;
    r_ready          = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_s1) begin
          owner_d  = OWNER_S1;
          araddr_d = s1_axil.araddr;
          state_d  = ARB_ADDR;
        end else if (grant_s0) begin
          owner_d  = OWNER_S0;
          araddr_d = s0_axil.araddr;
          state_d  = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (m_axil.arready) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        // The R beat is routed to the owner only; the other port sees zeros.
        if (owner_q == OWNER_S0) begin
          s0_axil.rvalid = m_axil.rvalid;
          s0_axil.rdata  = m_axil.rdata;
          s0_axil.rresp  = m_axil.rresp;
          r_ready        = s0_axil.rready;
        end else begin
          s1_axil.rvalid = m_axil.rvalid;
          s1_axil.rdata  = m_axil.rdata;
          s1_axil.rresp  = m_axil.rresp;
          r_ready        = s1_axil.rready;
        end
        if (m_axil.rvalid && r_ready) begin
          state_d = ARB_IDLE;
          owner_d = OWNER_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWNER_NONE;
      end
    endcase
  end

  // arvalid comes straight from the state register: no path from m_axil inputs.
  assign m_axil.arvalid = (state_q == ARB_ADDR);
  assign m_axil.araddr  = araddr_q;
  assign m_axil.rready  = r_ready;
  assign o_Busy         = (state_q != ARB_IDLE);
  assign o_Grant        = owner_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Self-checking bench for axil_read_arbiter: queued requesters, a behavioural
// downstream slave, a transaction-level arbiter model and an R-beat scoreboard.
module tb_axil_read_arbiter;
  import axil_read_arbiter_pkg::*;

  localparam int MAX_STREAK = 4;
  localparam int SB_W = XLEN + 2;

  // ---------------- clock / reset ----------------
  logic       i_Clock = 1'b0;
  logic       i_Reset_N;
  logic       o_Busy;
  logic [1:0] o_Grant;
  arb_state_e dbg_state;

  always #5 i_Clock = ~i_Clock;

  axil_read_arbiter_if s0_axil ();
  axil_read_arbiter_if s1_axil ();
  axil_read_arbiter_if m_axil ();

  axil_read_arbiter dut (
    .i_Clock   (i_Clock),
    .i_Reset_N (i_Reset_N),
    .s0_axil   (s0_axil),
    .s1_axil   (s1_axil),
    .m_axil    (m_axil),
    .o_Busy    (o_Busy),
    .o_Grant   (o_Grant),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int compared = 0;
  int mismatched = 0;

  logic [XLEN-1:0] q0[$];
  logic [XLEN-1:0] q1[$];
  logic [SB_W-1:0] exp_q[$];
  logic [XLEN-1:0] addr_log[$];
  logic [1:0]      gnt_seen[$];

  // Reference model: who holds the bus and which leg of the read is pending.
  int              mdl_phase;   // 0 free, 1 address pending, 2 response pending
  int              mdl_owner;   // 0 none, 1 S0, 2 S1
  logic [XLEN-1:0] mdl_addr;
  int              streak;

  // Downstream slave behaviour.
  int              ar_cnt, r_cnt;
  bit              sl_have;
  logic [XLEN-1:0] sl_rdata;
  logic [1:0]      sl_rresp;
  int              ar_delay_cfg, r_delay_cfg;
  bit              force_en;
  logic [XLEN-1:0] force_rdata;
  logic [1:0]      force_rresp;
  int              rr_block;
  bit              rr_rand;

  int s0_ar_pulses, s1_rvalid_cyc, arvalid_cyc, xfer_cnt;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ar_next();
    return (ar_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ar_delay_cfg;
  endfunction

  function automatic int r_next();
    return (r_delay_cfg < 0) ? int'($urandom_range(0, 3)) : r_delay_cfg;
  endfunction

  // Spec rule: S1 wins ties unless S1 has already won MAX_STREAK times in a
  // row while S0 waited (guard build only).
  function automatic int pick(bit r0, bit r1);
`ifdef ARB_STARVATION_GUARD_EN
    if (r0 && r1 && streak >= MAX_STREAK) return 1;
`endif
    if (r1) return 2;
    if (r0) return 1;
    return 0;
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic drive();
    s0_axil.arvalid = (q0.size() > 0);
    s0_axil.araddr  = (q0.size() > 0) ? q0[0] : $urandom();
    s1_axil.arvalid = (q1.size() > 0);
    s1_axil.araddr  = (q1.size() > 0) ? q1[0] : $urandom();
    m_axil.arready  = (ar_cnt == 0);
    m_axil.rvalid   = sl_have && (r_cnt == 0);
    m_axil.rdata    = sl_have ? sl_rdata : $urandom();
    m_axil.rresp    = sl_rresp;
    s0_axil.rready  = (rr_block > 0) ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    s1_axil.rready  = (rr_block > 0) ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic observe();
    bit              r0, r1;
    int              w;
    logic [1:0]      exp_g;
    logic            own_rvalid, own_rready, oth_rvalid;
    logic [XLEN-1:0] own_rdata, oth_rdata;
    logic [1:0]      own_rresp, oth_rresp;
    if (!i_Reset_N) begin
      mdl_phase = 0; mdl_owner = 0; streak = 0;
      q0.delete(); q1.delete(); exp_q.delete();
      sl_have = 0; r_cnt = 0; ar_cnt = ar_next(); rr_block = 0;
      return;
    end
    r0 = (q0.size() > 0);
    r1 = (q1.size() > 0);
    if (s0_axil.arready) s0_ar_pulses++;
    if (s1_axil.rvalid)  s1_rvalid_cyc++;
    if (m_axil.arvalid)  arvalid_cyc++;
    exp_g = (mdl_owner == 1) ? OWNER_S0 : OWNER_S1;
    case (mdl_phase)
      0: begin
        w = pick(r0, r1);
        chk("s0_arready", s0_axil.arready, w == 1);
        chk("s1_arready", s1_axil.arready, w == 2);
        chk("idle_m_arvalid", m_axil.arvalid, 1'b0);
        chk("idle_m_rready", m_axil.rready, 1'b0);
        chk("idle_busy", o_Busy, 1'b0);
        chk("idle_grant", o_Grant, OWNER_NONE);
        chk("idle_s0_rvalid", s0_axil.rvalid, 1'b0);
        chk("idle_s1_rvalid", s1_axil.rvalid, 1'b0);
        if (w != 0) begin
          mdl_owner = w;
          mdl_addr  = (w == 1) ? q0.pop_front() : q1.pop_front();
          if (w == 1)  streak = 0;
          else if (r0) streak = (streak < 7) ? streak + 1 : 7;
          else         streak = 0;
          mdl_phase = 1;
        end
      end
      1: begin
        chk("ar_m_arvalid", m_axil.arvalid, 1'b1);
        chk("ar_m_araddr", m_axil.araddr, mdl_addr);
        chk("ar_s0_arready", s0_axil.arready, 1'b0);
        chk("ar_s1_arready", s1_axil.arready, 1'b0);
        chk("ar_busy", o_Busy, 1'b1);
        chk("ar_grant", o_Grant, exp_g);
        chk("ar_m_rready", m_axil.rready, 1'b0);
        chk("ar_s0_rvalid", s0_axil.rvalid, 1'b0);
        chk("ar_s1_rvalid", s1_axil.rvalid, 1'b0);
        if (m_axil.arready) begin
          gnt_seen.push_back(o_Grant);
          mdl_phase = 2;
        end
      end
      default: begin
        own_rvalid = (mdl_owner == 1) ? s0_axil.rvalid : s1_axil.rvalid;
        own_rready = (mdl_owner == 1) ? s0_axil.rready : s1_axil.rready;
        own_rdata  = (mdl_owner == 1) ? s0_axil.rdata  : s1_axil.rdata;
        own_rresp  = (mdl_owner == 1) ? s0_axil.rresp  : s1_axil.rresp;
        oth_rvalid = (mdl_owner == 1) ? s1_axil.rvalid : s0_axil.rvalid;
        oth_rdata  = (mdl_owner == 1) ? s1_axil.rdata  : s0_axil.rdata;
        oth_rresp  = (mdl_owner == 1) ? s1_axil.rresp  : s0_axil.rresp;
        chk("r_m_arvalid", m_axil.arvalid, 1'b0);
        chk("r_busy", o_Busy, 1'b1);
        chk("r_grant", o_Grant, exp_g);
        chk("r_own_rvalid", own_rvalid, m_axil.rvalid);
        chk("r_m_rready", m_axil.rready, own_rready);
        chk("r_oth_rvalid", oth_rvalid, 1'b0);
        chk("r_oth_rdata", oth_rdata, '0);
        chk("r_oth_rresp", oth_rresp, 2'b00);
        if (m_axil.rvalid) begin
          chk("r_beat", {own_rresp, own_rdata}, (exp_q.size() > 0) ? exp_q[0] : 'x);
          if (own_rready) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
            mdl_phase = 0;
            mdl_owner = 0;
          end
        end
      end
    endcase
    // Downstream slave: R leg first, then AR capture.
    if (m_axil.rvalid && rr_block > 0) rr_block--;
    if (sl_have) begin
      if (m_axil.rvalid && m_axil.rready) sl_have = 0;
      else if (!m_axil.rvalid && r_cnt > 0) r_cnt--;
    end
    if (m_axil.arvalid) begin
      if (m_axil.arready) begin
        addr_log.push_back(m_axil.araddr);
        sl_have = 1;
        r_cnt   = r_next();
        if (force_en) begin
          sl_rdata = force_rdata; sl_rresp = force_rresp; force_en = 0;
        end else begin
          sl_rdata = $urandom(); sl_rresp = 2'($urandom_range(0, 3));
        end
        exp_q.push_back({sl_rresp, sl_rdata});
        ar_cnt = ar_next();
      end else if (ar_cnt > 0) begin
        ar_cnt--;
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge i_Clock);
    observe();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mdl_phase != 0 || sl_have) && n < budget) begin
      cycle();
      n++;
    end
    compared++;
    assert (q0.size() == 0 && q1.size() == 0 && mdl_phase == 0 && !sl_have) else begin
      mismatched++;
      $error("FAIL %s_timeout: observed=still busy expected=idle within %0d cycles", tag, budget);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete(); gnt_seen.delete();
    s0_ar_pulses = 0; s1_rvalid_cyc = 0; arvalid_cyc = 0; xfer_cnt = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [XLEN-1:0] a, b;
    int pushed;
    i_Reset_N = 1'b0;
    mdl_phase = 0; mdl_owner = 0; mdl_addr = '0; streak = 0;
    sl_have = 0; r_cnt = 0; ar_cnt = 0; sl_rdata = '0; sl_rresp = 2'b00;
    ar_delay_cfg = 0; r_delay_cfg = 0; force_en = 0; force_rdata = '0;
    force_rresp = 2'b00; rr_block = 0; rr_rand = 0;
    clear_logs();

    // Reset state
    repeat (3) cycle();
    i_Reset_N = 1'b1;
    cycle();
    chk("rst_m_araddr", m_axil.araddr, '0);
    chk("rst_s0_rdata", s0_axil.rdata, '0);
    chk("rst_s1_rdata", s1_axil.rdata, '0);
    chk("rst_s0_rresp", s0_axil.rresp, 2'b00);
    chk("rst_state", dbg_state, ARB_IDLE);

    // Solo S0 read, 2-cycle slave latency, fixed data
    clear_logs();
    ar_delay_cfg = 0; ar_cnt = 0; r_delay_cfg = 2;
    force_en = 1; force_rdata = 32'h0000_0013; force_rresp = RRESP_OKAY;
    q0.push_back(32'h8000_1000);
    wait_idle("solo", 50);
    chk("solo_arready_pulses", s0_ar_pulses, 1);
    chk("solo_m_araddr", (addr_log.size() > 0) ? addr_log[0] : 'x, 32'h8000_1000);
    chk("solo_s1_rvalid_cycles", s1_rvalid_cyc, 0);
    chk("solo_xfers", xfer_cnt, 1);

    // Simultaneous requests: S1 first, then S0
    clear_logs();
    q0.push_back(32'h0000_0100);
    q1.push_back(32'h0000_0200);
    wait_idle("simul", 50);
    chk("simul_addr0", (addr_log.size() > 0) ? addr_log[0] : 'x, 32'h0000_0200);
    chk("simul_addr1", (addr_log.size() > 1) ? addr_log[1] : 'x, 32'h0000_0100);
    chk("simul_grant0", (gnt_seen.size() > 0) ? gnt_seen[0] : 2'bxx, 2'b10);
    chk("simul_grant1", (gnt_seen.size() > 1) ? gnt_seen[1] : 2'bxx, 2'b01);

    // Backpressure: arready low 5 cycles, s1 rready low 3 cycles
    clear_logs();
    ar_delay_cfg = 5; ar_cnt = 5; r_delay_cfg = 0; rr_block = 3;
    a = $urandom();
    q1.push_back(a);
    wait_idle("bp", 60);
    chk("bp_xfers", xfer_cnt, 1);
    chk("bp_m_araddr", (addr_log.size() > 0) ? addr_log[0] : 'x, a);
    chk("bp_arvalid_cycles", arvalid_cyc, 6);
    chk("bp_s1_rvalid_cycles", s1_rvalid_cyc, 4);

    // Error response forwarded, next request served normally
    clear_logs();
    ar_delay_cfg = 0; ar_cnt = 0; r_delay_cfg = 1;
    a = $urandom(); b = $urandom();
    force_en = 1; force_rdata = $urandom(); force_rresp = RRESP_SLVERR;
    q0.push_back(a);
    wait_idle("err", 50);
    q0.push_back(b);
    wait_idle("err_next", 50);
    chk("err_xfers", xfer_cnt, 2);
    chk("err_next_addr", (addr_log.size() > 1) ? addr_log[1] : 'x, b);

    // Both requesters continuously valid
    clear_logs();
    ar_delay_cfg = -1; r_delay_cfg = -1; rr_rand = 1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back($urandom());
      q1.push_back($urandom());
    end
    wait_idle("streak", 2000);
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVATION_GUARD_EN
      chk($sformatf("streak_grant%0d", i), (gnt_seen.size() > i) ? gnt_seen[i] : 2'bxx,
          (i % 5 == 4) ? 2'b01 : 2'b10);
`else
      chk($sformatf("streak_grant%0d", i), (gnt_seen.size() > i) ? gnt_seen[i] : 2'bxx, 2'b10);
`endif
    end
    chk("streak_xfers", xfer_cnt, 20);

    // Reset while in the response phase
    clear_logs();
    ar_delay_cfg = 0; ar_cnt = 0; r_delay_cfg = 8; rr_rand = 0;
    q0.push_back($urandom());
    begin
      int n = 0;
      while (mdl_phase != 2 && n < 30) begin
        cycle();
        n++;
      end
    end
    chk("mid_reached_data", dbg_state, ARB_DATA);
    i_Reset_N = 1'b0;
    cycle();
    i_Reset_N = 1'b1;
    cycle();
    chk("mid_busy", o_Busy, 1'b0);
    chk("mid_m_arvalid", m_axil.arvalid, 1'b0);
    chk("mid_m_rready", m_axil.rready, 1'b0);
    chk("mid_m_araddr", m_axil.araddr, '0);
    chk("mid_state", dbg_state, ARB_IDLE);
    clear_logs();
    r_delay_cfg = 1;
    a = $urandom();
    force_en = 1; force_rdata = $urandom(); force_rresp = RRESP_OKAY;
    q0.push_back(a);
    wait_idle("post_rst", 50);
    chk("post_rst_xfers", xfer_cnt, 1);
    chk("post_rst_addr", (addr_log.size() > 0) ? addr_log[0] : 'x, a);

    // Random mix of both requesters, delays and R backpressure
    clear_logs();
    ar_delay_cfg = -1; r_delay_cfg = -1; rr_rand = 1;
    pushed = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 3) begin
        q0.push_back($urandom()); pushed++;
      end
      if ($urandom_range(0, 2) == 0 && q1.size() < 3) begin
        q1.push_back($urandom()); pushed++;
      end
      cycle();
    end
    wait_idle("rand", 3000);
    chk("rand_xfers", xfer_cnt, pushed);
    chk("sb_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
Two-requester arbiter that shares one AXI4-Lite read master between the instruction fetch unit (port S0) and the data load path (port S1). It sits between the CPU core's memory units and the system interconnect. It serialises reads with one outstanding transaction, captures the winner's address and routes the response back to the owner only.

Parameters:
XLEN, 32, address/data width; must match cpu_core_params.
MAX_DATA_STREAK, 4, consecutive S1 grants allowed while S0 waits (starvation guard only).

Ports:
i_Clock  in  1  system clock
i_Reset_N  in  1  synchronous active-low reset
s0_axil_araddr  in  XLEN  instruction read address
s0_axil_arvalid  in  1  instruction AR valid
s0_axil_arready  out  1  instruction AR ready
s0_axil_rdata  out  XLEN  instruction read data
s0_axil_rresp  out  2  instruction read response
s0_axil_rvalid  out  1  instruction R valid
s0_axil_rready  in  1  instruction R ready
s1_axil_araddr  in  XLEN  data read address
s1_axil_arvalid  in  1  data AR valid
s1_axil_arready  out  1  data AR ready
s1_axil_rdata  out  XLEN  data read data
s1_axil_rresp  out  2  data read response
s1_axil_rvalid  out  1  data R valid
s1_axil_rready  in  1  data R ready
m_axil_araddr  out  XLEN  downstream read address (registered)
m_axil_arvalid  out  1  downstream AR valid
m_axil_arready  in  1  downstream AR ready
m_axil_rdata  in  XLEN  downstream read data
m_axil_rresp  in  2  downstream read response
m_axil_rvalid  in  1  downstream R valid
m_axil_rready  out  1  downstream R ready
o_Busy  out  1  high whenever state != IDLE
o_Grant  out  2  one-hot owner {S1,S0}; 00 in IDLE

Behaviour:
- Single clock i_Clock. Reset is synchronous and active-low on i_Reset_N: sampled on the rising edge only.
- Reset: state IDLE, owner none, m_axil_araddr=0, streak counter=0. All valid/ready outputs 0, all s*_rdata/rresp 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Arbitrate combinationally. Default is strict S1 priority.
  - The winner's s*_arready=1 in the same cycle. The address is latched into m_axil_araddr and the owner is latched.
  - Next state is ADDR. The loser's arready stays 0.
  - No arvalid: stay in IDLE.
- ADDR:
  - m_axil_arvalid=1 and the address is held stable.
  - On m_axil_arready, go to DATA.
  - Both s*_arready=0.
- DATA:
  - Owner's s*_rvalid=m_axil_rvalid. Owner's rdata/rresp=m_axil_rdata/rresp, combinational passthrough.
  - m_axil_rready=owner's rready. Non-owner rvalid=0 and rdata/rresp=0.
  - On m_axil_rvalid && m_axil_rready, go to IDLE.
- Latency: accept at cycle N; m_axil_arvalid rises at N+1. Minimum turnaround is 3 cycles (accept, AR, R), then the next grant can occur.
- The rresp value, including SLVERR/DECERR, is forwarded unmodified. The arbiter never retries.
- Simultaneous arvalid in IDLE: S1 wins unless the starvation guard forces S0.
- A requester dropping arvalid before the grant is legal and is ignored.
- Reset mid-operation: immediate return to IDLE and the in-flight transaction is abandoned. The downstream slave shares i_Reset_N, so no stale R beat arrives.
- No combinational path from m_axil_* inputs to m_axil_arvalid.

Optional Feature:
ARB_STARVATION_GUARD_EN:
- Defined: a 3-bit saturating streak counter increments on each S1 grant made while s0_axil_arvalid=1.
  - When the count equals MAX_DATA_STREAK, the next IDLE arbitration grants S0 even if S1 is requesting.
  - The counter clears on any S0 grant, or when s0_axil_arvalid is low at an S1 grant.
- Undefined: no counter, strict S1 priority. S0 can starve indefinitely.

Decomposition:
- Shared package/header (cpu_core_params.vh): XLEN, AXI RRESP codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), arbiter state encodings.
- One natural sub-module, axil_arb_priority_sel: combinational winner select plus the streak counter, with the counter present only under ARB_STARVATION_GUARD_EN.

Test Plan:
- Solo S0 read of 0x8000_1000, slave returns rdata=0x0000_0013 with OKAY after 2 cycles:
  - s0_arready pulses once.
  - m_araddr=0x8000_1000.
  - s0_rvalid carries 0x13.
  - s1_rvalid stays 0.
- S0 and S1 assert arvalid in the same cycle, addresses 0x100 and 0x200:
  - S1 is served first (m_araddr=0x200), then S0 (0x100).
  - o_Grant sequence is 10, then 01.
- Backpressure: m_arready held low 5 cycles and s1_rready low 3 cycles after rvalid:
  - m_arvalid and the address stay stable throughout.
  - Exactly one transfer completes and the return to IDLE follows the R handshake.
- Error response: slave returns rresp=2'b10 for S0:
  - s0_rresp=2'b10 with rvalid.
  - Arbiter returns to IDLE and accepts the next request normally.
- With ARB_STARVATION_GUARD_EN, MAX_DATA_STREAK=4, both requesters continuously valid:
  - Grants are S1,S1,S1,S1,S0, repeating.
  - Without the macro, every grant is S1.
- i_Reset_N low for 1 cycle while in DATA:
  - Next cycle is IDLE with all valid/ready outputs 0 and o_Busy=0.
  - A subsequent S0 request completes correctly.
